// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs and per-word latched CPOL/CPHA/bit-order/divider.
// A word runs IDLE -> SETUP -> SHIFT -> HOLD -> GAP, or chains HOLD -> SETUP when ss_hold is set.
module spi_master_fifo #(
   parameter int DATA_W     = 24,
   parameter int NUM_SS     = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_cpol,
   input  logic              cfg_cpha,
   input  logic              cfg_lsb_first,
   input  logic [NUM_SS-1:0] cfg_ss_sel,
   input  logic              cfg_ss_hold,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              rx_overflow,
   input  logic              clr_ovf,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = $clog2(2 * DATA_W);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t state_q, state_d;

   // ---------------- TX FIFO ----------------
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [AW-1:0]     tx_wp, tx_rp;
   logic [CW-1:0]     tx_cnt;
   logic              tx_push, tx_pop, tx_empty;
   logic [DATA_W-1:0] tx_head;

   assign tx_ready = (tx_cnt != FULL_CNT);
   assign tx_empty = (tx_cnt == '0);
   assign tx_push  = tx_valid && tx_ready;
   assign tx_head  = tx_mem[tx_rp];

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= tx_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + AW'(1);
         if (tx_pop)  tx_rp <= tx_rp + AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + CW'(1);
            2'b01:   tx_cnt <= tx_cnt - CW'(1);
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     rx_wp, rx_rp;
   logic [CW-1:0]     rx_cnt;
   logic              rx_push, rx_pop, rx_full, word_done, ovf_set;
   logic [DATA_W-1:0] rx_sr;

   assign rx_valid = (rx_cnt != '0);
   assign rx_full  = (rx_cnt == FULL_CNT);
   assign rx_pop   = rx_valid && rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
   assign rx_push  = word_done && (!rx_full || rx_pop);
   assign ovf_set  = word_done && rx_full && !rx_pop;
   assign rx_data  = rx_valid ? rx_mem[rx_rp] : '0;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= rx_sr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_wp       <= '0;
         rx_rp       <= '0;
         rx_cnt      <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + AW'(1);
         if (rx_pop)  rx_rp <= rx_rp + AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + CW'(1);
            2'b01:   rx_cnt <= rx_cnt - CW'(1);
            default: rx_cnt <= rx_cnt;
         endcase
         if (ovf_set)      rx_overflow <= 1'b1;
         else if (clr_ovf) rx_overflow <= 1'b0;
      end
   end

   // ---------------- FSM ----------------
   logic [DIV_W-1:0]  hp_cnt, div_l;
   logic [EW-1:0]     edge_cnt;
   logic              cpha_l, lsb_l;
   logic [NUM_SS-1:0] ss_l;
   logic [DATA_W-1:0] tx_sr;
   logic              tick, start_word, shift_tick, lead, do_sample, do_drive;

   assign tick = (hp_cnt == div_l);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start_word = 1'b0;
      word_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!tx_empty) begin
               start_word = 1'b1;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: if (tick) state_d = ST_SHIFT;
         ST_SHIFT: if (tick && edge_cnt == LAST_EDGE) state_d = ST_HOLD;
         ST_HOLD: begin
            if (tick) begin
               word_done = 1'b1;
               if (cfg_ss_hold && !tx_empty) begin
                  start_word = 1'b1;
                  state_d    = ST_SETUP;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP:  if (tick) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign tx_pop     = start_word;
   assign shift_tick = (state_q == ST_SHIFT) && tick;
   assign lead       = ~edge_cnt[0];
   // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge drives
   assign do_sample  = shift_tick && (lead ^ cpha_l);
   assign do_drive   = shift_tick && !(lead ^ cpha_l) && (edge_cnt != LAST_EDGE);

   assign ss_n = (state_q == ST_SETUP || state_q == ST_SHIFT || state_q == ST_HOLD) ?
                 ~ss_l : '1;
   assign busy = (state_q != ST_IDLE) || !tx_empty;

   function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hp_cnt   <= '0;
         edge_cnt <= '0;
         div_l    <= '0;
         cpha_l   <= 1'b0;
         lsb_l    <= 1'b0;
         ss_l     <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         tx_sr    <= '0;
         rx_sr    <= '0;
      end else begin
         hp_cnt <= (state_q == ST_IDLE || tick) ? '0 : hp_cnt + DIV_W'(1);
         if (state_q == ST_IDLE) sclk <= cfg_cpol;
         if (start_word) begin
            div_l    <= cfg_div;
            cpha_l   <= cfg_cpha;
            lsb_l    <= cfg_lsb_first;
            ss_l     <= cfg_ss_sel;
            sclk     <= cfg_cpol;
            edge_cnt <= '0;
            rx_sr    <= '0;
            if (!cfg_cpha) begin
               mosi  <= first_bit(tx_head, cfg_lsb_first);
               tx_sr <= shift_out(tx_head, cfg_lsb_first);
            end else begin
               tx_sr <= tx_head;
            end
         end
         if (shift_tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + EW'(1);
         end
         if (do_sample)
            rx_sr <= lsb_l ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
         if (do_drive) begin
            mosi  <= first_bit(tx_sr, lsb_l);
            tx_sr <= shift_out(tx_sr, lsb_l);
         end
      end
   end

endmodule
